// File: rtl/block_xfer_pkg.sv
// Shared types and default sizes for the word block feeder.
// Holds the feeder FSM state enum and default WSIZE/WORDS_PER_BLOCK/LENW.
package block_xfer_pkg;

  localparam int WSIZE_DEF = 32;
  localparam int WPB_DEF   = 4;
  localparam int LENW_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/feeder_out_stage.sv
// One-word output holding register with load/hold handshake.
// Ports: i_load/i_load_data fill it, i_hold stalls; o_data/o_valid out,
// o_xfer = word leaves this cycle, o_can_load = may accept a new word.
module feeder_out_stage
  import block_xfer_pkg::*;
#(
  parameter int WSIZE = WSIZE_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WSIZE-1:0] i_load_data,
  input  logic             i_hold,
  output logic [WSIZE-1:0] o_data,
  output logic             o_valid,
  output logic             o_xfer,
  output logic             o_can_load
);

  logic [WSIZE-1:0] r_data;
  logic             r_valid;

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_xfer     = r_valid & ~i_hold;
  assign o_can_load = ~r_valid | ~i_hold;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_valid <= 1'b1;
    end else if (o_xfer) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/word_block_feeder.sv
// Pops a counted run of words from a FIFO into a registered output stage.
// Ports: start/word_count, fifo_* side, word_out/ready/hold, busy/done/
// words_sent. FEEDER_BLOCK_PAD_EN adds zero padding to a block multiple.
module word_block_feeder
  import block_xfer_pkg::*;
#(
  parameter int WSIZE           = WSIZE_DEF,
  parameter int WORDS_PER_BLOCK = WPB_DEF,
  parameter int LENW            = LENW_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LENW-1:0]  word_count,
  input  logic [WSIZE-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_read_en,
  output logic [WSIZE-1:0] word_out,
  output logic             word_out_ready,
  input  logic             word_out_hold,
  output logic             busy,
  output logic             done,
  output logic [LENW-1:0]  words_sent
);

  localparam int BW = $clog2(WORDS_PER_BLOCK);

  feeder_state_t    r_state;
  logic [LENW-1:0]  r_remaining;
  logic [LENW-1:0]  r_words_sent;

  logic             w_rd_en;
  logic             w_pad_load;
  logic             w_load;
  logic [WSIZE-1:0] w_load_data;
  logic             w_valid;
  logic             w_xfer;
  logic             w_can_load;
  logic             w_last;

  // reset_n gates the pop so a reset cycle never consumes a FIFO word
  assign w_rd_en = reset_n
                 && (r_state == S_XFER)
                 && (r_remaining != '0)
                 && !fifo_empty
                 && w_can_load;

  assign w_last = (r_remaining == '0)
               && (!w_valid || w_xfer);

`ifdef FEEDER_BLOCK_PAD_EN
  logic [BW-1:0] r_blk_pos;
  logic [BW-1:0] w_commit;

  // words already sent plus the one in the stage, modulo block size
  assign w_commit   = r_blk_pos + BW'(w_valid);
  assign w_pad_load = (r_state == S_PAD)
                   && (w_commit != '0)
                   && w_can_load;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_blk_pos <= '0;
    end else if (r_state == S_IDLE) begin
      r_blk_pos <= '0;
    end else if (w_xfer) begin
      r_blk_pos <= r_blk_pos + BW'(1);
    end
  end
`else
  assign w_pad_load = 1'b0;
`endif

  assign w_load      = w_rd_en | w_pad_load;
  assign w_load_data = w_rd_en ? fifo_data : '0;

  feeder_out_stage #(
    .WSIZE (WSIZE)
  ) u_out (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_hold      (word_out_hold),
    .o_data      (word_out),
    .o_valid     (w_valid),
    .o_xfer      (w_xfer),
    .o_can_load  (w_can_load)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_words_sent <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining  <= word_count;
            r_words_sent <= '0;
            r_state      <= (word_count == '0) ? S_DONE : S_XFER;
          end
        end
        S_XFER: begin
          if (w_rd_en)
            r_remaining <= r_remaining - LENW'(1);
          if (w_xfer)
            r_words_sent <= r_words_sent + LENW'(1);
          if (w_last) begin
`ifdef FEEDER_BLOCK_PAD_EN
            r_state <= S_PAD;
`else
            r_state <= S_DONE;
`endif
          end
        end
        S_PAD: begin
`ifdef FEEDER_BLOCK_PAD_EN
          if ((r_blk_pos == '0) && !w_valid)
            r_state <= S_DONE;
`else
          r_state <= S_DONE;
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_read_en   = w_rd_en;
  assign word_out_ready = w_valid;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign words_sent     = r_words_sent;

endmodule

// File: tb/tb_word_block_feeder.sv
// Directed self-checking bench for word_block_feeder.
// FIFO model and downstream sink live here; expectations are hand-built.
module tb_word_block_feeder;

`ifdef FEEDER_BLOCK_PAD_EN
  localparam int PAD_ON = 1;
`else
  localparam int PAD_ON = 0;
`endif

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] word_count;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic [31:0] word_out;
  logic        word_out_ready;
  logic        word_out_hold;
  logic        busy;
  logic        done;
  logic [15:0] words_sent;

  logic [31:0] mem [64];
  int          rd_ptr;
  int          wr_ptr;

  logic [31:0] rx [$];
  logic [31:0] ex [$];
  int          done_cnt;
  int          rd_cnt;
  int          rdy_cnt;
  int          cyc;
  int          first_cap;
  int          last_cap;

  int errors;
  int checks;

  word_block_feeder dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .word_count     (word_count),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .word_out       (word_out),
    .word_out_ready (word_out_ready),
    .word_out_hold  (word_out_hold),
    .busy           (busy),
    .done           (done),
    .words_sent     (words_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr % 64];

  always @(posedge clock) begin
    logic        pop;
    logic        cap;
    logic [31:0] w;
    pop = fifo_read_en;
    cap = word_out_ready && !word_out_hold;
    w   = word_out;
    if (done) done_cnt++;
    if (fifo_read_en) rd_cnt++;
    if (word_out_ready) rdy_cnt++;
    cyc++;
    #1;
    if (pop) rd_ptr++;
    if (cap) begin
      rx.push_back(w);
      if (first_cap < 0) first_cap = cyc;
      last_cap = cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rx.delete();
    ex.delete();
    done_cnt  = 0;
    rd_cnt    = 0;
    rdy_cnt   = 0;
    first_cap = -1;
    last_cap  = -1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = base + 32'(i);
      wr_ptr++;
    end
  endtask

  task automatic go(input logic [15:0] n);
    start      = 1'b1;
    word_count = n;
    @(negedge clock);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_len"}, 32'(rx.size()), 32'(ex.size()));
    for (int i = 0; i < rx.size() && i < ex.size(); i++)
      chk(tag, rx[i], ex[i]);
  endtask

  initial begin
    int n;
    logic bad;
    errors        = 0;
    checks        = 0;
    rd_ptr        = 0;
    wr_ptr        = 0;
    cyc           = 0;
    reset_n       = 1'b0;
    start         = 1'b0;
    word_count    = '0;
    word_out_hold = 1'b0;
    clr();

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdy", {31'd0, word_out_ready}, 32'd0);
    chk("rst_word", word_out, 32'd0);
    chk("rst_sent", {16'd0, words_sent}, 32'd0);
    chk("rst_rden", {31'd0, fifo_read_en}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 8 words back to back, with a start pulse while busy
    clr();
    fill(8, 32'h100);
    for (int i = 0; i < 8; i++) ex.push_back(32'h100 + 32'(i));
    go(16'd8);
    n = 0;
    while (rx.size() == 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    start      = 1'b1;
    word_count = 16'd3;
    @(negedge clock);
    start      = 1'b0;
    wait_done("a_done");
    chk_rx("a_data");
    chk("a_sent", {16'd0, words_sent}, 32'd8);
    chk("a_pulse", 32'(done_cnt), 32'd1);
    chk("a_span", 32'(last_cap - first_cap), 32'd7);
    chk("a_idle", {31'd0, busy}, 32'd0);

    // 5 words, padded to a block of 4 when padding is built in
    clr();
    fill(5, 32'h200);
    for (int i = 0; i < 5; i++) ex.push_back(32'h200 + 32'(i));
    if (PAD_ON != 0)
      for (int i = 0; i < 3; i++) ex.push_back(32'h0);
    go(16'd5);
    wait_done("b_done");
    chk_rx("b_data");
    chk("b_sent", {16'd0, words_sent}, 32'd5);
    chk("b_pulse", 32'(done_cnt), 32'd1);

    // downstream hold on word 2 for 3 cycles
    clr();
    fill(4, 32'h300);
    for (int i = 0; i < 4; i++) ex.push_back(32'h300 + 32'(i));
    go(16'd4);
    n = 0;
    while (!(word_out_ready && word_out == 32'h301) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("c_word2", word_out, 32'h301);
    word_out_hold = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (fifo_read_en || word_out != 32'h301 || !word_out_ready)
        bad = 1'b1;
      @(negedge clock);
    end
    chk("c_held", {31'd0, bad}, 32'd0);
    word_out_hold = 1'b0;
    wait_done("c_done");
    chk_rx("c_data");
    chk("c_sent", {16'd0, words_sent}, 32'd4);

    // FIFO runs dry after 2 of 4 words
    clr();
    fill(2, 32'h400);
    for (int i = 0; i < 4; i++) ex.push_back(32'h400 + 32'(i));
    go(16'd4);
    n = 0;
    while (rx.size() < 2 && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (5) @(negedge clock);
    chk("d_busy", {31'd0, busy}, 32'd1);
    chk("d_rdy", {31'd0, word_out_ready}, 32'd0);
    chk("d_sent2", {16'd0, words_sent}, 32'd2);
    fill(2, 32'h402);
    wait_done("d_done");
    chk_rx("d_data");
    chk("d_sent", {16'd0, words_sent}, 32'd4);
    chk("d_pulse", 32'(done_cnt), 32'd1);

    // reset after 3 of 8 words, then a clean 4-word transfer
    clr();
    fill(8, 32'h500);
    go(16'd8);
    n = 0;
    while (rx.size() < 3 && n < 50) begin
      @(negedge clock);
      n++;
    end
    reset_n = 1'b0;
    #1;
    chk("e_rden_rst", {31'd0, fifo_read_en}, 32'd0);
    @(negedge clock);
    chk("e_busy", {31'd0, busy}, 32'd0);
    chk("e_rdy", {31'd0, word_out_ready}, 32'd0);
    chk("e_word", word_out, 32'd0);
    chk("e_sent0", {16'd0, words_sent}, 32'd0);
    chk("e_done0", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    rd_ptr  = wr_ptr;
    @(negedge clock);
    clr();
    fill(4, 32'h600);
    for (int i = 0; i < 4; i++) ex.push_back(32'h600 + 32'(i));
    go(16'd4);
    wait_done("e_done");
    chk_rx("e_data");
    chk("e_sent", {16'd0, words_sent}, 32'd4);
    chk("e_pulse", 32'(done_cnt), 32'd1);

    // zero-length transfer
    clr();
    go(16'd0);
    chk("f_done", {31'd0, done}, 32'd1);
    chk("f_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("f_done_off", {31'd0, done}, 32'd0);
    chk("f_idle", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
    chk("f_rden", 32'(rd_cnt), 32'd0);
    chk("f_rdy", 32'(rdy_cnt), 32'd0);
    chk("f_pulse", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
